// File: rtl/exe_stage_pkg.sv
// Shared widths and ALU op bit positions for the decode/execute boundary.
// Imported by exe_stage, exe_stage_alu and the decode stage.
package exe_stage_pkg;

    localparam int DATA_W    = 32;
    localparam int ID_EXE_W  = 180;
    localparam int EXE_MEM_W = 71;
    localparam int WR_BUS_W  = 6;
    localparam int FWD_W     = 39;
    localparam int ALU_OP_W  = 12;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational 12-op ALU, one-hot alu_op; an all-zero op yields 0.
// Ports: alu_op[11:0], src1[31:0], src2[31:0] in; result[31:0] out.
module exe_stage_alu
    import exe_stage_pkg::*;
(
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [DATA_W-1:0]   src1,
    input  logic [DATA_W-1:0]   src2,
    output logic [DATA_W-1:0]   result
);

    logic [DATA_W-1:0] add_r;
    logic [DATA_W-1:0] sub_r;
    logic [DATA_W-1:0] slt_r;
    logic [DATA_W-1:0] sltu_r;
    logic [DATA_W-1:0] sll_r;
    logic [DATA_W-1:0] srl_r;
    logic [DATA_W-1:0] sra_r;
    logic [4:0]        sa;

    assign sa     = src2[4:0];
    assign add_r  = src1 + src2;
    assign sub_r  = src1 - src2;
    assign slt_r  = {31'd0, $signed(src1) < $signed(src2)};
    assign sltu_r = {31'd0, src1 < src2};
    assign sll_r  = src1 << sa;
    assign srl_r  = src1 >> sa;
    assign sra_r  = $signed(src1) >>> sa;

    // AND-OR mux keeps an all-zero op at 0 and avoids priority logic.
    assign result = ({DATA_W{alu_op[ALU_ADD]}}  & add_r)
                  | ({DATA_W{alu_op[ALU_SUB]}}  & sub_r)
                  | ({DATA_W{alu_op[ALU_SLT]}}  & slt_r)
                  | ({DATA_W{alu_op[ALU_SLTU]}} & sltu_r)
                  | ({DATA_W{alu_op[ALU_AND]}}  & (src1 & src2))
                  | ({DATA_W{alu_op[ALU_NOR]}}  & ~(src1 | src2))
                  | ({DATA_W{alu_op[ALU_OR]}}   & (src1 | src2))
                  | ({DATA_W{alu_op[ALU_XOR]}}  & (src1 ^ src2))
                  | ({DATA_W{alu_op[ALU_SLL]}}  & sll_r)
                  | ({DATA_W{alu_op[ALU_SRL]}}  & srl_r)
                  | ({DATA_W{alu_op[ALU_SRA]}}  & sra_r)
                  | ({DATA_W{alu_op[ALU_LUI]}}  & src2);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: latches the decode bundle, runs the ALU, issues the data-SRAM
// request and hands results to memory over valid/allowin.
// Ports: clk, resetn (sync, active-low); id_exe_valid/exe_allowin/id_exe_bus
// from decode; mem_allowin/exe_mem_valid/exe_mem_bus to memory; exe_wr_bus
// hazard info; data_sram_*. Optional macro EXE_FWD_EN adds exe_fwd_bus.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 id_exe_valid,
    output logic                 exe_allowin,
    input  logic [ID_EXE_W-1:0]  id_exe_bus,
    input  logic                 mem_allowin,
    output logic                 exe_mem_valid,
    output logic [EXE_MEM_W-1:0] exe_mem_bus,
    output logic [WR_BUS_W-1:0]  exe_wr_bus,
    output logic                 data_sram_en,
    output logic [3:0]           data_sram_we,
    output logic [DATA_W-1:0]    data_sram_addr,
    output logic [DATA_W-1:0]    data_sram_wdata
`ifdef EXE_FWD_EN
    ,
    output logic [FWD_W-1:0]     exe_fwd_bus
`endif
);

    logic                exe_valid;
    logic                ready_go;
    logic [ID_EXE_W-1:0] bus_r;

    logic                gr_we;
    logic                mem_we;
    logic                res_from_mem;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   src1;
    logic [DATA_W-1:0]   src2;
    logic [4:0]          dest;
    logic [DATA_W-1:0]   rkd_value;
    logic [DATA_W-1:0]   inst;
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   alu_result;
    logic                unused_inst;

    assign {gr_we, mem_we, res_from_mem, alu_op, src1, src2,
            dest, rkd_value, inst, pc} = bus_r;
    assign unused_inst = ^inst;

    assign ready_go      = 1'b1;
    assign exe_allowin   = ~exe_valid | (ready_go & mem_allowin);
    assign exe_mem_valid = exe_valid & ready_go;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            exe_valid <= 1'b0;
        end else if (exe_allowin) begin
            exe_valid <= id_exe_valid;
        end
    end

    // Bundle is data only; exe_valid qualifies it, so no reset needed.
    always_ff @(posedge clk) begin
        if (id_exe_valid && exe_allowin) begin
            bus_r <= id_exe_bus;
        end
    end

    exe_stage_alu u_alu (
        .alu_op (alu_op),
        .src1   (src1),
        .src2   (src2),
        .result (alu_result)
    );

    assign exe_mem_bus = exe_valid
                       ? {res_from_mem, gr_we, dest, alu_result, pc}
                       : '0;
    assign exe_wr_bus  = {exe_valid & gr_we, dest};

    // Strobe only in the transfer cycle; resetn kills a request that
    // would otherwise fire while the stage is being flushed.
    assign data_sram_en    = resetn & exe_valid & mem_allowin
                           & (mem_we | res_from_mem);
    assign data_sram_we    = {4{data_sram_en & mem_we}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;

`ifdef EXE_FWD_EN
    assign exe_fwd_bus = exe_valid
                       ? {gr_we, res_from_mem, dest, alu_result}
                       : '0;
`endif

endmodule
